// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter and its side-write queue.
package rf_write_arbiter_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] tgt;
        logic [DATA_W-1:0]    data;
    } rf_write_t;

endpackage

// File: rtl/rf_write_arbiter_wq_fifo.sv
// In-order side-write queue with per-entry valid bits, target-match kill and pending-register mask.
module rf_wq_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned REGS  = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_step,
    input  logic                 i_push,
    input  logic [REG_IDX_W-1:0] i_push_tgt,
    input  logic [DATA_W-1:0]    i_push_data,
    input  logic                 i_pop,
    input  logic                 i_kill_a_en,
    input  logic [REG_IDX_W-1:0] i_kill_a_tgt,
    input  logic                 i_kill_b_en,
    input  logic [REG_IDX_W-1:0] i_kill_b_tgt,
    output rf_write_t            o_head,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [CNT_W-1:0]     o_count,
    output logic [REGS-1:0]      o_pending_mask
);

    logic [DEPTH-1:0]     r_valid;
    logic [REG_IDX_W-1:0] r_tgt  [DEPTH];
    logic [DATA_W-1:0]    r_data [DEPTH];
    logic [PTR_W-1:0]     r_rd;
    logic [PTR_W-1:0]     r_wr;
    logic [CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]     w_kill;
    logic [REGS-1:0]      w_mask;

    always_comb begin
        w_kill = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_kill[i] = (i_kill_a_en && (r_tgt[i] == i_kill_a_tgt)) ||
                        (i_kill_b_en && (r_tgt[i] == i_kill_b_tgt));
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_mask[r_tgt[i]] = 1'b1;
            end
        end
    end

    assign o_empty        = (r_count == '0);
    assign o_full         = (r_count == CNT_W'(DEPTH));
    assign o_count        = r_count;
    assign o_pending_mask = w_mask;

    // Head counts as issuable only if it survives this step's kill check.
    assign o_head.we   = !o_empty && r_valid[r_rd] && !w_kill[r_rd];
    assign o_head.tgt  = r_tgt[r_rd];
    assign o_head.data = r_data[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tgt[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_step) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_valid[r_rd] <= 1'b0;
                r_rd          <= r_rd + 1'b1;
            end
            if (i_push) begin
                r_valid[r_wr] <= 1'b1;
                r_tgt[r_wr]   <= i_push_tgt;
                r_data[r_wr]  <= i_push_data;
                r_wr          <= r_wr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// GPR write-port arbiter: pipeline slots own ports A/B, side writes queue and drain into idle ports.
// Optional same-step side bypass when the queue is empty: define RF_ARB_BYPASS_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned REGS  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       halt,
    input  logic                       p1_we,
    input  logic [REG_IDX_W-1:0]       p1_tgt,
    input  logic [DATA_W-1:0]          p1_data,
    input  logic                       p2_we,
    input  logic [REG_IDX_W-1:0]       p2_tgt,
    input  logic [DATA_W-1:0]          p2_data,
    input  logic                       s_valid,
    input  logic [REG_IDX_W-1:0]       s_tgt,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic                       rf_we_a,
    output logic [REG_IDX_W-1:0]       rf_tgt_a,
    output logic [DATA_W-1:0]          rf_data_a,
    output logic                       rf_we_b,
    output logic [REG_IDX_W-1:0]       rf_tgt_b,
    output logic [DATA_W-1:0]          rf_data_b,
    output logic [REGS-1:0]            pending_mask,
    output logic [$clog2(DEPTH):0]     q_count
);

    rf_write_t w_head;
    rf_write_t w_port_a;
    rf_write_t w_port_b;
    rf_write_t r_port_a;
    rf_write_t r_port_b;
    logic      w_step;
    logic      w_empty;
    logic      w_full;
    logic      w_side_kill;
    logic      w_side_live;
    logic      w_push;
    logic      w_pop;

    assign w_step  = clk_en && !halt;
    assign s_ready = !w_full;

    // A side write racing a same-target pipeline write is older, so it is dropped.
    assign w_side_kill = (p1_we && (s_tgt == p1_tgt)) || (p2_we && (s_tgt == p2_tgt));
    assign w_side_live = s_valid && s_ready && (s_tgt != '0) && !w_side_kill;

    always_comb begin
        w_port_a = '0;
        w_port_b = '0;
        w_pop    = 1'b0;
        w_push   = w_side_live;

        if (p1_we && (p1_tgt != '0)) begin
            w_port_a = '{we: 1'b1, tgt: p1_tgt, data: p1_data};
        end
        if (p2_we && (p2_tgt != '0) && !(p1_we && (p1_tgt == p2_tgt))) begin
            w_port_b = '{we: 1'b1, tgt: p2_tgt, data: p2_data};
        end

        if (!w_empty) begin
            if (!w_head.we) begin
                w_pop = 1'b1;
            end else if (!w_port_a.we) begin
                w_port_a = w_head;
                w_pop    = 1'b1;
            end else if (!w_port_b.we) begin
                w_port_b = w_head;
                w_pop    = 1'b1;
            end
        end
`ifdef RF_ARB_BYPASS_EN
        else if (w_side_live) begin
            if (!w_port_a.we) begin
                w_port_a = '{we: 1'b1, tgt: s_tgt, data: s_data};
                w_push   = 1'b0;
            end else if (!w_port_b.we) begin
                w_port_b = '{we: 1'b1, tgt: s_tgt, data: s_data};
                w_push   = 1'b0;
            end
        end
`endif
    end

    rf_wq_fifo #(
        .DEPTH (DEPTH),
        .REGS  (REGS)
    ) u_wq (
        .clk            (clk),
        .rst            (rst),
        .i_step         (w_step),
        .i_push         (w_push),
        .i_push_tgt     (s_tgt),
        .i_push_data    (s_data),
        .i_pop          (w_pop),
        .i_kill_a_en    (p1_we),
        .i_kill_a_tgt   (p1_tgt),
        .i_kill_b_en    (p2_we),
        .i_kill_b_tgt   (p2_tgt),
        .o_head         (w_head),
        .o_empty        (w_empty),
        .o_full         (w_full),
        .o_count        (q_count),
        .o_pending_mask (pending_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port_a <= '0;
            r_port_b <= '0;
        end else if (w_step) begin
            r_port_a <= w_port_a;
            r_port_b <= w_port_b;
        end
    end

    assign rf_we_a   = r_port_a.we;
    assign rf_tgt_a  = r_port_a.tgt;
    assign rf_data_a = r_port_a.data;
    assign rf_we_b   = r_port_b.we;
    assign rf_tgt_b  = r_port_b.tgt;
    assign rf_data_b = r_port_b.data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter (default build) against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned REGS  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en, halt;
    logic        p1_we, p2_we, s_valid;
    logic [4:0]  p1_tgt, p2_tgt, s_tgt;
    logic [31:0] p1_data, p2_data, s_data;
    logic        s_ready;
    logic        rf_we_a, rf_we_b;
    logic [4:0]  rf_tgt_a, rf_tgt_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic [REGS-1:0] pending_mask;
    logic [$clog2(DEPTH):0] q_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .REGS(REGS)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt),
        .p1_we(p1_we), .p1_tgt(p1_tgt), .p1_data(p1_data),
        .p2_we(p2_we), .p2_tgt(p2_tgt), .p2_data(p2_data),
        .s_valid(s_valid), .s_tgt(s_tgt), .s_data(s_data), .s_ready(s_ready),
        .rf_we_a(rf_we_a), .rf_tgt_a(rf_tgt_a), .rf_data_a(rf_data_a),
        .rf_we_b(rf_we_b), .rf_tgt_b(rf_tgt_b), .rf_data_b(rf_data_b),
        .pending_mask(pending_mask), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        int unsigned tgt;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [37:0] m_a, m_b;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].valid) m[mq[i].tgt] = 1'b1;
        return m;
    endfunction

    task automatic check_all();
        check("port_a", {26'd0, rf_we_a, rf_tgt_a, rf_data_a}, {26'd0, m_a});
        check("port_b", {26'd0, rf_we_b, rf_tgt_b, rf_data_b}, {26'd0, m_b});
        check("q_count", 64'(q_count), 64'(mq.size()));
        check("pending_mask", 64'(pending_mask), 64'(model_mask()));
        check("s_ready", 64'(s_ready), 64'(mq.size() < DEPTH));
    endtask

    task automatic model_reset();
        mq.delete();
        m_a = '0;
        m_b = '0;
    endtask

    // Reference: slots own their ports, queue entries die on any matching slot target,
    // head leaves first (invalid heads just vanish), then the side request joins the tail.
    task automatic model_step();
        bit rdy;
        bit skill;
        if (!clk_en || halt) return;
        rdy = mq.size() < DEPTH;
        m_a = '0;
        m_b = '0;
        if (p1_we && p1_tgt != 0) m_a = {1'b1, p1_tgt, p1_data};
        if (p2_we && p2_tgt != 0 && !(p1_we && p1_tgt == p2_tgt)) m_b = {1'b1, p2_tgt, p2_data};
        foreach (mq[i])
            if ((p1_we && mq[i].tgt == p1_tgt) || (p2_we && mq[i].tgt == p2_tgt)) mq[i].valid = 0;
        if (mq.size() > 0) begin
            if (!mq[0].valid) mq.delete(0);
            else if (!m_a[37]) begin m_a = {1'b1, 5'(mq[0].tgt), mq[0].data}; mq.delete(0); end
            else if (!m_b[37]) begin m_b = {1'b1, 5'(mq[0].tgt), mq[0].data}; mq.delete(0); end
        end
        skill = (p1_we && s_tgt == p1_tgt) || (p2_we && s_tgt == p2_tgt);
        if (s_valid && rdy && s_tgt != 0 && !skill)
            mq.push_back('{valid: 1'b1, tgt: s_tgt, data: s_data});
    endtask

    task automatic set_idle();
        clk_en = 1; halt = 0;
        p1_we = 0; p1_tgt = 0; p1_data = 0;
        p2_we = 0; p2_tgt = 0; p2_data = 0;
        s_valid = 0; s_tgt = 0; s_data = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_slots(input bit we1, input int t1, input int d1,
                             input bit we2, input int t2, input int d2);
        p1_we = we1; p1_tgt = 5'(t1); p1_data = 32'(d1);
        p2_we = we2; p2_tgt = 5'(t2); p2_data = 32'(d2);
    endtask

    task automatic set_side(input bit v, input int t, input int d);
        s_valid = v; s_tgt = 5'(t); s_data = 32'(d);
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        model_reset();
        check("rst_q_count", 64'(q_count), 0);
        check("rst_mask", 64'(pending_mask), 0);
        check("rst_we", {rf_we_a, rf_we_b}, 0);
        check_all();
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1;
        set_idle();
        model_reset();
        #12;
        check_all();
        rst = 0;
        @(posedge clk); #1;
        check_all();

        // Both slots busy while the side fills the queue with r5..r8.
        set_slots(1, 3, 'h11, 1, 4, 'h22);
        for (int i = 0; i < 4; i++) begin
            set_side(1, 5 + i, 'h100 + i);
            step();
        end
        check("full_mask", 64'(pending_mask), 64'h1E0);
        check("full_ready", 64'(s_ready), 0);
        set_side(1, 9, 'h999);
        step();
        set_idle();
        for (int i = 0; i < 6; i++) step();

        // Same-target slots: slot 1 wins, port B idle.
        set_slots(1, 7, 'hAAAA, 1, 7, 'hBBBB);
        step();
        check("same_a", {rf_we_a, rf_tgt_a, rf_data_a}, {1'b1, 5'd7, 32'hAAAA});
        check("same_b_we", 64'(rf_we_b), 0);

        // Kill: queued r9 superseded by a pipeline write before it drains.
        set_slots(1, 1, 'h1, 1, 2, 'h2);
        set_side(1, 9, 'h1234);
        step();
        check("kill_pending", 64'(pending_mask[9]), 1);
        set_side(0, 0, 0);
        set_slots(1, 9, 'h5678, 1, 2, 'h3);
        step();
        check("kill_a", {rf_we_a, rf_tgt_a, rf_data_a}, {1'b1, 5'd9, 32'h5678});
        check("kill_cleared", 64'(pending_mask[9]), 0);
        set_idle();
        for (int i = 0; i < 3; i++) step();

        // Halt holds two queued entries.
        set_slots(1, 1, 'h1, 1, 2, 'h2);
        set_side(1, 11, 'hB0B);
        step();
        set_side(1, 12, 'hC0C);
        step();
        set_idle();
        halt = 1;
        for (int i = 0; i < 5; i++) step();
        check("halt_count", 64'(q_count), 2);
        halt = 0;
        for (int i = 0; i < 4; i++) step();

        // Reset with three queued entries.
        set_slots(1, 1, 'h1, 1, 2, 'h2);
        for (int i = 0; i < 3; i++) begin
            set_side(1, 20 + i, 'h200 + i);
            step();
        end
        check("pre_rst_count", 64'(q_count), 3);
        async_reset();
        set_idle();
        step();

        // Randomized traffic with occasional stalls and one mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            clk_en  = ($urandom_range(0, 99) < 90);
            halt    = ($urandom_range(0, 99) < 5);
            p1_we   = ($urandom_range(0, 99) < 40);
            p1_tgt  = 5'($urandom_range(0, 9));
            p1_data = $urandom;
            p2_we   = ($urandom_range(0, 99) < 40);
            p2_tgt  = 5'($urandom_range(0, 9));
            p2_data = $urandom;
            s_valid = ($urandom_range(0, 99) < 50);
            s_tgt   = 5'($urandom_range(0, 12));
            s_data  = $urandom;
            step();
            if (n == 1500) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the GPR file's two write ports between the writeback stage's two result slots and one long-latency side requester (divider / uncached-load return). Pipeline slots always win; side writes are buffered in a small in-order queue and drained into idle ports. Exports a pending-register mask so decode can stall readers of queued targets. Sits between writeback and the register file.

Parameters:
DEPTH, 4, side-write queue entries (power of two, >=2)
REGS, 32, number of GPRs (mask width)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clk_en  in  1  global clock enable; state and outputs hold when 0
halt  in  1  core halted; state and outputs hold when 1
p1_we  in  1  writeback slot 1 write enable
p1_tgt  in  5  slot 1 target
p1_data  in  32  slot 1 data
p2_we  in  1  writeback slot 2 write enable
p2_tgt  in  5  slot 2 target
p2_data  in  32  slot 2 data
s_valid  in  1  side write request
s_tgt  in  5  side target
s_data  in  32  side data
s_ready  out  1  queue can accept (valid/ready handshake)
rf_we_a  out  1  regfile port A enable
rf_tgt_a  out  5  port A target
rf_data_a  out  32  port A data
rf_we_b  out  1  regfile port B enable
rf_tgt_b  out  5  port B target
rf_data_b  out  32  port B data
pending_mask  out  REGS  bit r set while a queued write targets r
q_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async): queue empty, q_count=0, all rf_we_*=0, rf_tgt/data_*=0, pending_mask=0, s_ready=1.
- Advance: a "step" occurs on posedge clk with clk_en && !halt; otherwise everything holds.
- Outputs are registered: inputs sampled at a step appear on rf_* after that step (1-cycle latency).
- Handshake: side write accepted at a step when s_valid && s_ready; s_ready = (q_count < DEPTH), registered-equivalent (depends only on state). s_tgt==0 accepted and discarded.
- Port assignment per step: slot 1 -> port A if p1_we; slot 2 -> port B if p2_we. If p1_we && p2_we && p1_tgt==p2_tgt, slot 1 wins, port B idle. Tgt 0 writes are suppressed (we forced 0).
- Drain: queue head issues on the lowest free port (A before B), at most one entry per step. Free = no pipeline write assigned to it.
- Kill rule: a pipeline write is younger than any queued side write; a queued entry whose tgt matches p1 or p2 tgt (with we) in the same step is invalidated (never written); invalid entries pop without using a port.
- Enqueue + dequeue same step: count unchanged. Full queue with drain in same step: s_ready still 0 that step (no fall-through).
- Queue pointers wrap modulo DEPTH.
- pending_mask = OR of one-hot tgts of valid queue entries; updated at each step.
- Reset mid-operation discards queued writes.

Optional Feature:
RF_ARB_BYPASS_EN: when defined, a side request arriving with queue empty and a free port is written in the same step's output (no enqueue), latency 1 instead of 2; kill rule applies (dropped if a pipeline slot targets same reg). Undefined: every side write passes through the queue; minimum latency 2 steps.

Decomposition:
Shared package: REG_IDX_W=5, DATA_W=32, struct rf_write_t {we, tgt, data}. One natural sub-module: rf_wq_fifo (DEPTH-entry queue with per-entry valid bit, match-and-kill port, pending_mask output); arbiter logic in top.

Test Plan:
- Reset: assert rst mid-stream with 3 queued entries -> q_count=0, pending_mask=0, rf_we_a=rf_we_b=0 immediately.
- Both slots busy (p1 r3=0x11, p2 r4=0x22) four steps while side pushes r5..r8 -> s_ready drops after 4 accepts, pending_mask=0x1E0; slots idle -> r5..r8 drain one per step on port A.
- Same-target slots: p1 r7=0xAAAA, p2 r7=0xBBBB -> rf_we_a=1 data 0xAAAA, rf_we_b=0.
- Kill: side r9=0x1234 queued, slots busy; then p1 writes r9=0x5678 -> r9 final 0x5678, queued entry never issued, pending bit 9 clears.
- Stall hold: queue holding 2 entries, halt=1 for 5 cycles -> no rf writes, q_count=2 unchanged; resumes draining on release.
- Bypass (RF_ARB_BYPASS_EN): queue empty, p2 idle, side r10=0xCAFE -> appears on port with 1-cycle latency; without macro 2 steps.
